scaled_clock_bank: RTL and testbench

Parametrised bank of independent clock-enable dividers: each channel divides the system clock by a runtime-programmable ratio and produces either a 50%-duty scaled clock (toggle mode) or a one-cycle tick (pulse mode). Divisor changes are glitch-free and take effect only at a period boundary. A global sync restarts all channels phase-aligned. The bank feeds slow-rate logic (display refresh, debouncers, timers) from the single board clock; all outputs are registered and are used as enables, never as clocks.

---
 rtl/scaled_clock_pkg.sv | 11 +
 rtl/scaled_clock_channel.sv | 75 +++++++
 rtl/scaled_clock_bank.sv | 41 ++++
 tb/tb_scaled_clock_bank.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaled_clock_pkg.sv
// Shared types and limits for the scaled clock-enable divider bank.
package scaled_clock_pkg;

    localparam int unsigned MAX_CHANNELS = 8;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } scaled_mode_t;

endpackage

// File: rtl/scaled_clock_channel.sv
// One divider channel: period counter, shadow/active divisor and registered
// scaled clock / rise strobe. Divisor and mode only change at a period boundary.
module scaled_clock_channel
    import scaled_clock_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 50
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    input  logic             sync,
    output logic             scaledclk,
    output logic             rise
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] div_active;
    scaled_mode_t     mode_active;

    logic [WIDTH-1:0] load_div;
    logic [WIDTH-1:0] next_shadow;
    logic             terminal;
    logic             sclk_next;

    always_comb begin
        // A zero divisor is stored as 1 so the terminal compare never underflows.
        load_div    = (div_value == '0) ? ONE : div_value;
        next_shadow = div_load ? load_div : shadow;
        terminal    = (count == div_active - ONE);
        if (mode_active == MODE_PULSE) begin
            sclk_next = terminal;
        end else begin
            sclk_next = terminal ? ~scaledclk : scaledclk;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count       <= '0;
            shadow      <= DEF_DIV;
            div_active  <= DEF_DIV;
            mode_active <= MODE_TOGGLE;
            scaledclk   <= 1'b0;
            rise        <= 1'b0;
        end else begin
            shadow <= next_shadow;
            if (!enable || sync) begin
                count       <= '0;
                scaledclk   <= 1'b0;
                rise        <= 1'b0;
                div_active  <= next_shadow;
                mode_active <= scaled_mode_t'(mode);
            end else begin
                scaledclk <= sclk_next;
                rise      <= sclk_next & ~scaledclk;
                if (terminal) begin
                    count       <= '0;
                    div_active  <= next_shadow;
                    mode_active <= scaled_mode_t'(mode);
                end else begin
                    count <= count + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/scaled_clock_bank.sv
// Bank of independent clock-enable dividers sharing one divisor bus and sync.
module scaled_clock_bank
    import scaled_clock_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] mode,
    input  logic [WIDTH-1:0]    div_value,
    input  logic [CHANNELS-1:0] div_load,
    input  logic                sync,
    output logic [CHANNELS-1:0] scaledclk,
    output logic [CHANNELS-1:0] rise
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("scaled_clock_bank: CHANNELS out of range");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        scaled_clock_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable[c]),
            .mode      (mode[c]),
            .div_value (div_value),
            .div_load  (div_load[c]),
            .sync      (sync),
            .scaledclk (scaledclk[c]),
            .rise      (rise[c])
        );
    end

endmodule

// File: tb/tb_scaled_clock_bank.sv
// Self-checking bench: period-level reference model plus directed literal checks.
module tb_scaled_clock_bank;

    localparam int CH  = 2;
    localparam int W   = 16;
    localparam int DEF = 50;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] enable;
    logic [CH-1:0] mode;
    logic [W-1:0]  div_value;
    logic [CH-1:0] div_load;
    logic          sync;
    logic [CH-1:0] scaledclk;
    logic [CH-1:0] rise;

    always #5 clock = ~clock;

    scaled_clock_bank #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .div_value (div_value),
        .div_load  (div_load),
        .sync      (sync),
        .scaledclk (scaledclk),
        .rise      (rise)
    );

    int errors = 0;
    int checks = 0;
    bit check_on = 1'b0;

    // Reference: each channel is a sequence of periods; a period of length d
    // ends after d enabled cycles, at which point the output level is decided.
    int m_shadow [CH];
    int m_len    [CH];
    int m_done   [CH];
    bit m_pulse  [CH];
    bit m_out    [CH];
    bit m_rise   [CH];

    logic [CH-1:0] exp_s;
    logic [CH-1:0] exp_r;

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_shadow[c] = DEF;
            m_len[c]    = DEF;
            m_done[c]   = 0;
            m_pulse[c]  = 1'b0;
            m_out[c]    = 1'b0;
            m_rise[c]   = 1'b0;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            int nd;
            bit prev;
            nd   = div_load[c] ? ((div_value == 0) ? 1 : int'(div_value)) : m_shadow[c];
            prev = m_out[c];
            if (!enable[c] || sync) begin
                m_done[c]  = 0;
                m_out[c]   = 1'b0;
                m_len[c]   = nd;
                m_pulse[c] = mode[c];
            end else begin
                m_done[c] = m_done[c] + 1;
                if (m_done[c] == m_len[c]) begin
                    m_out[c]   = m_pulse[c] ? 1'b1 : !m_out[c];
                    m_done[c]  = 0;
                    m_len[c]   = nd;
                    m_pulse[c] = mode[c];
                end else if (m_pulse[c]) begin
                    m_out[c] = 1'b0;
                end
            end
            m_rise[c]   = m_out[c] && !prev;
            m_shadow[c] = nd;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clock);
            model_step();
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (check_on) begin
            for (int c = 0; c < CH; c++) begin
                exp_s[c] = m_out[c];
                exp_r[c] = m_rise[c];
            end
            chk("model_scaledclk", scaledclk, exp_s);
            chk("model_rise", rise, exp_r);
        end
    end

    initial begin
        int highs;
        int rise_bad;
        reset     = 1'b1;
        enable    = '0;
        mode      = '0;
        div_value = '0;
        div_load  = '0;
        sync      = 1'b0;
        model_reset();
        check_on  = 1'b1;
        run(3);
        reset = 1'b0;
        run(2);
        chk("reset_scaledclk", scaledclk, 2'b00);
        chk("reset_rise", rise, 2'b00);

        // ch0 toggle at default divisor 50
        enable[0] = 1'b1;
        run(49);
        chk("t1_before_first_rise", scaledclk, 2'b00);
        run(1);
        chk("t1_first_rise_sclk", scaledclk, 2'b01);
        chk("t1_first_rise", rise, 2'b01);
        run(1);
        chk("t1_rise_one_cycle", rise, 2'b00);
        run(48);
        chk("t1_high_end", scaledclk, 2'b01);
        run(1);
        chk("t1_low_start", scaledclk, 2'b00);

        // ch1 pulse at D=4, then D=1
        div_value   = 16'd4;
        div_load[1] = 1'b1;
        run(1);
        div_load[1] = 1'b0;
        enable[1]   = 1'b1;
        mode[1]     = 1'b1;
        highs = 0;
        rise_bad = 0;
        for (int i = 0; i < 40; i++) begin
            run(1);
            if (scaledclk[1]) highs++;
            if (rise[1] !== scaledclk[1]) rise_bad++;
        end
        chk_int("t2_pulse_highs_in_40", highs, 10);
        chk_int("t2_rise_eq_sclk", rise_bad, 0);
        div_value   = 16'd1;
        div_load[1] = 1'b1;
        run(1);
        div_load[1] = 1'b0;
        run(8);
        highs = 0;
        rise_bad = 0;
        for (int i = 0; i < 10; i++) begin
            run(1);
            if (scaledclk[1]) highs++;
            if (rise[1]) rise_bad++;
        end
        chk_int("t2_d1_constant_high", highs, 10);
        chk_int("t2_d1_no_rise", rise_bad, 0);

        // ch0: load D=10 at count 3 of a fresh D=50 period
        enable[0] = 1'b0;
        run(1);
        enable[0] = 1'b1;
        run(3);
        div_value   = 16'd10;
        div_load[0] = 1'b1;
        run(1);
        div_load[0] = 1'b0;
        run(45);
        chk("t3_still_low_edge48", scaledclk[0], 1'b0);
        run(1);
        chk("t3_high_edge49", scaledclk[0], 1'b1);
        run(9);
        chk("t3_high_edge58", scaledclk[0], 1'b1);
        run(1);
        chk("t3_low_edge59", scaledclk[0], 1'b0);
        run(10);
        chk("t3_high_edge69", scaledclk[0], 1'b1);
        // load coincident with the terminal at edge 79
        run(9);
        div_value   = 16'd3;
        div_load[0] = 1'b1;
        run(1);
        div_load[0] = 1'b0;
        chk("t3_coincident_low", scaledclk[0], 1'b0);
        run(2);
        chk("t3_coincident_still_low", scaledclk[0], 1'b0);
        run(1);
        chk("t3_coincident_high", scaledclk[0], 1'b1);

        // two toggle channels D=6 / D=9 with sync mid-period
        div_value = 16'd6;
        div_load  = 2'b01;
        mode      = 2'b00;
        run(1);
        div_value = 16'd9;
        div_load  = 2'b10;
        run(1);
        div_load  = 2'b00;
        run(20);
        sync = 1'b1;
        run(1);
        sync = 1'b0;
        chk("t4_sync_clears_sclk", scaledclk, 2'b00);
        chk("t4_sync_clears_rise", rise, 2'b00);
        run(5);
        chk("t4_before_rise", scaledclk, 2'b00);
        run(1);
        chk("t4_ch0_rise_at_6", rise, 2'b01);
        run(3);
        chk("t4_ch1_rise_at_9", rise, 2'b10);
        chk("t4_both_high_at_9", scaledclk, 2'b11);

        // drop ch0 enable while high
        enable[0] = 1'b0;
        run(1);
        chk("t5_drop_clears", scaledclk[0], 1'b0);
        run(4);
        chk("t5_held_low", scaledclk[0], 1'b0);
        enable[0] = 1'b1;
        run(5);
        chk("t5_restart_low", scaledclk[0], 1'b0);
        run(1);
        chk("t5_restart_full_d", scaledclk[0], 1'b1);
        // D=0 behaves as D=1
        enable[0]   = 1'b0;
        div_value   = 16'd0;
        div_load[0] = 1'b1;
        run(1);
        div_load[0] = 1'b0;
        enable[0]   = 1'b1;
        run(1);
        chk("t5_d0_high", scaledclk[0], 1'b1);
        run(1);
        chk("t5_d0_low", scaledclk[0], 1'b0);
        run(1);
        chk("t5_d0_high_again", scaledclk[0], 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 15) == 0) enable[c] = ~enable[c];
                if ($urandom_range(0, 31) == 0) mode[c] = ~mode[c];
                div_load[c] = ($urandom_range(0, 15) == 0);
            end
            div_value = W'($urandom_range(0, 12));
            sync      = ($urandom_range(0, 99) == 0);
            run(1);
        end
        div_load = '0;
        sync     = 1'b0;

        // asynchronous reset between edges
        enable    = 2'b11;
        mode      = 2'b00;
        div_value = 16'd2;
        div_load  = 2'b11;
        run(1);
        div_load  = 2'b00;
        run(4);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_async_sclk", scaledclk, 2'b00);
        chk("t6_async_rise", rise, 2'b00);
        run(3);
        reset  = 1'b0;
        enable = 2'b01;
        run(49);
        chk("t6_default_div_low", scaledclk, 2'b00);
        run(1);
        chk("t6_default_div_rise", rise, 2'b01);

        check_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
